pipe_chain: RTL and testbench
=============================

Name: pipe_chain

Overview:
- Parametrised N-stage pipeline backbone for the next-generation core datapath.
- Replaces the fixed four global-stall pipeline registers with a chain of per-stage valid/data slots.
- Adds per-stage hold, bubble collapsing (an empty stage accepts even when downstream is stalled), and indexed flush.
- Provides a ready/valid handshake at both ends plus retire/kill counters for debug.

Parameters:
STAGES, 4, number of pipeline slots (≥1); slot 0 is fed by the input, slot STAGES-1 drives the output
WIDTH, 64, packet width in bits per slot
CNT_W, 32, width of the retire and kill counters
IDX_W, $clog2(STAGES) (min 1), width of the flush index

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  producer offers a packet to slot 0
in_data  in  WIDTH  packet from the producer
in_ready  out  1  slot 0 accepts this cycle
stage_hold  in  STAGES  bit i: logic at stage i cannot complete; slot i must keep its packet
flush_req  in  1  flush request
flush_idx  in  IDX_W  highest stage index killed by the flush
out_ready  in  1  consumer accepts the packet from the last slot
out_valid  out  1  last slot presents a completed packet
out_data  out  WIDTH  last slot packet
stage_valid  out  STAGES  bit i: slot i holds a live packet
stage_data  out  STAGES*WIDTH  slot i data at bits [i*WIDTH +: WIDTH]
occupancy  out  $clog2(STAGES+1)  population count of stage_valid
retired  out  CNT_W  packets delivered at the output
killed  out  CNT_W  live packets destroyed by flushes

Behaviour:
- Reset (async, rst=1): all stage_valid=0, all slot data=0, retired=0, killed=0, so out_valid=0 and occupancy=0. in_ready follows its combinational equation; with all slots empty it is 1 unless a flush is pending.
- Ready chain (combinational): ready[STAGES]=out_ready; ready[i] = !v[i] | (!stage_hold[i] & ready[i+1]).
- Pass condition: pass[i] = v[i] & !stage_hold[i].
- Output side: out_valid = pass[STAGES-1]; out_data = d[STAGES-1]; the output fires when out_valid & out_ready.
- Input side: in_ready = ready[0] & !flush_req; the input fires when in_valid & in_ready.
- Slot update at the clock edge when ready[i]=1 and the slot is not flushed:
  - i>0: v[i] <= pass[i-1]; d[i] <= d[i-1] when pass[i-1], else d[i] holds.
  - i=0: v[0] <= input fire; d[0] <= in_data on fire.
  - A held slot that cannot move keeps v/d unchanged.
  - A held slot with a vacant successor sends a bubble downstream.
- Latency: one cycle per slot with no holds, so the input reaches out_valid STAGES cycles after acceptance. Full throughput is one packet per cycle.
- Bubble collapse: an invalid slot always loads, even when its successor is stalled. A stall therefore compresses gaps upstream of the blocking point.
- Flush, when flush_req=1:
  - Slots 0..flush_idx get v <= 0 at the edge; data is retained but meaningless.
  - The input is refused.
  - Slots above flush_idx update normally, except that slot flush_idx+1 loads a bubble if ready (nothing crosses the flush boundary).
  - Flush overrides stage_hold.
  - flush_idx ≥ STAGES-1 kills every slot; the output may still fire in the same cycle.
  - Precedence: an output fire and a flush of the last slot in the same cycle count as retired, not killed.
- Counters:
  - retired += 1 on each output fire.
  - killed += popcount of v[0..flush_idx] on each flush cycle, excluding a last-slot packet that fired that cycle.
  - Both wrap modulo 2^CNT_W.
- occupancy reflects the registered valids (not the next state).
- Simultaneous input fire and output fire keep occupancy constant.
- STAGES=1 degenerates to a single registered slot: in_ready = !v | (!hold & out_ready).

Decomposition:
- Shared package (includes): STAGES default constant, function popcount, and the pipe_flush struct {req, idx}.
- Per-slot logic is a natural sub-module, pipe_slot: one valid/data register with load/flush/bubble select.
- pipe_chain instantiates STAGES copies in a generate loop and owns the ready chain, counters and occupancy.

Test Plan:
- Streaming: STAGES=4, in_valid=1 with data 1,2,3… for 10 cycles, out_ready=1 → first out_valid in cycle 4 with out_data=1; then one packet per cycle in order; retired=10 at the end.
- Backpressure: fill 4 slots, drop out_ready for 3 cycles → in_ready=0, stage_data frozen, occupancy=4; restore out_ready → the sequence continues with no loss or duplication.
- Bubble collapse: slots hold packets A,–,B,– (slot3 empty), stage_hold[2]=1 for 2 cycles → A advances into slot1 and slot3 receives a bubble; in_ready stays 1; B is emitted after the hold is released.
- Indexed flush: slots 0..3 all valid, flush_req=1 with flush_idx=1 → next cycle v[0]=v[1]=0, slot2 empty (bubble), slot3 holds the former slot2 packet; killed=2; input refused during the flush cycle.
- Flush and output in the same cycle: last slot valid, out_ready=1, flush_idx=3 → the packet is emitted, retired+1, killed = the other valid slots only.
- Async reset mid-stream: assert rst between edges with 3 slots valid → stage_valid=0, out_valid=0, counters=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_chain_pkg.sv
// Shared types and helpers for the pipe_chain datapath backbone.
// Sizing limits below bound STAGES to at most MaxStages slots.
package pipe_chain_pkg;

  localparam int unsigned StagesDefault = 4;
  localparam int unsigned MaxStages     = 256;
  localparam int unsigned MaxIdxW       = 8;
  localparam int unsigned PopW          = 9;

  typedef struct packed {
    logic               req;
    logic [MaxIdxW-1:0] idx;
  } pipe_flush_t;

  function automatic logic [PopW-1:0] popcount(input logic [MaxStages-1:0] vec);
    logic [PopW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(MaxStages); i++) begin
      cnt = cnt + PopW'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/pipe_chain_slot.sv
// One pipeline slot: a valid/data register that loads from upstream,
// takes a bubble, holds, or is killed by a flush.
module pipe_slot
  import pipe_chain_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             kill_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;

  // Kill wins over load; data is left in place when the slot is invalidated.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (kill_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = valid_i;
      if (valid_i) begin
        data_d = data_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_chain.sv
// N-stage valid/data pipeline with per-stage hold, bubble collapsing,
// indexed flush, ready/valid ends and retire/kill debug counters.
module pipe_chain
  import pipe_chain_pkg::*;
#(
  parameter int unsigned STAGES = StagesDefault,
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned IDX_W  = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          in_ready,
  input  logic [STAGES-1:0]             stage_hold,
  input  logic                          flush_req,
  input  logic [IDX_W-1:0]              flush_idx,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
  output logic [STAGES-1:0]             stage_valid,
  output logic [STAGES*WIDTH-1:0]       stage_data,
  output logic [$clog2(STAGES+1)-1:0]   occupancy,
  output logic [CNT_W-1:0]              retired,
  output logic [CNT_W-1:0]              killed
);

  localparam int unsigned OccW = $clog2(STAGES + 1);

  logic [STAGES-1:0] v, pass, kill, up_valid, kill_live;
  logic [STAGES:0]   ready;
  logic [WIDTH-1:0]  d [STAGES];
  pipe_flush_t       flush;
  logic              in_fire, out_fire;
  logic [CNT_W-1:0]  retired_d, retired_q, killed_d, killed_q;

  // Ready ripples from the consumer back towards slot 0.
  always_comb begin
    ready         = '0;
    ready[STAGES] = out_ready;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      ready[i] = !v[i] | (!stage_hold[i] & ready[i+1]);
    end
  end

  always_comb begin
    flush.req = flush_req;
    flush.idx = MaxIdxW'(flush_idx);
    pass      = v & ~stage_hold;
    for (int i = 0; i < int'(STAGES); i++) begin
      kill[i] = flush.req && (MaxIdxW'(i) <= flush.idx);
    end
    in_ready  = ready[0] & !flush.req;
    in_fire   = in_valid & in_ready;
    out_valid = pass[STAGES-1];
    out_data  = d[STAGES-1];
    out_fire  = out_valid & out_ready;
    // A killed upstream slot passes nothing across the flush boundary.
    up_valid    = '0;
    up_valid[0] = in_fire;
    for (int i = 1; i < int'(STAGES); i++) begin
      up_valid[i] = pass[i-1] & !kill[i-1];
    end
  end

  for (genvar g = 0; g < int'(STAGES); g++) begin : g_slot
    logic [WIDTH-1:0] src_data;
    if (g == 0) begin : g_head
      assign src_data = in_data;
    end else begin : g_body
      assign src_data = d[g-1];
    end

    pipe_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load_i  (ready[g]),
      .kill_i  (kill[g]),
      .valid_i (up_valid[g]),
      .data_i  (src_data),
      .valid_o (v[g]),
      .data_o  (d[g])
    );

    assign stage_data[g*WIDTH +: WIDTH] = d[g];
  end

  // A last-slot packet that leaves this cycle is retired, never killed.
  always_comb begin
    kill_live = v & kill;
    if (out_fire) begin
      kill_live[STAGES-1] = 1'b0;
    end
    retired_d = retired_q + CNT_W'(out_fire);
    killed_d  = killed_q + CNT_W'(popcount(MaxStages'(kill_live)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
      killed_q  <= '0;
    end else begin
      retired_q <= retired_d;
      killed_q  <= killed_d;
    end
  end

  assign stage_valid = v;
  assign occupancy   = OccW'(popcount(MaxStages'(v)));
  assign retired     = retired_q;
  assign killed      = killed_q;

endmodule

// File: tb/tb_pipe_chain.sv
// Self-checking bench for pipe_chain: scoreboard on the output stream plus
// a step table for hold, bubble and flush sequences.
module tb_pipe_chain;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [63:0]   in_data;
  logic          in_ready;
  logic [3:0]    stage_hold;
  logic          flush_req;
  logic [1:0]    flush_idx;
  logic          out_ready;
  logic          out_valid;
  logic [63:0]   out_data;
  logic [3:0]    stage_valid;
  logic [255:0]  stage_data;
  logic [2:0]    occupancy;
  logic [31:0]   retired;
  logic [31:0]   killed;

  int checks   = 0;
  int failures = 0;
  logic [63:0] sb [$];
  logic [63:0] sb_exp;

  pipe_chain #(
    .STAGES (4),
    .WIDTH  (64),
    .CNT_W  (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .stage_hold  (stage_hold),
    .flush_req   (flush_req),
    .flush_idx   (flush_idx),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .stage_valid (stage_valid),
    .stage_data  (stage_data),
    .occupancy   (occupancy),
    .retired     (retired),
    .killed      (killed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 20 && occupancy != 3'd0; k++) cyc();
    chk(name, 64'(occupancy), 64'd0);
  endtask

  // Scoreboard: push accepted inputs, pop on every output fire.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow actual=%0h required=none", out_data);
        end else begin
          sb_exp = sb.pop_front();
          chk("sb_data", out_data, sb_exp);
        end
      end
      if (in_valid && in_ready) sb.push_back(in_data);
    end
  end

  typedef struct {
    logic        iv;
    logic [63:0] id;
    logic [3:0]  hold;
    logic        fr;
    logic [1:0]  fi;
    logic        ordy;
    logic        exp_ir;
    logic [3:0]  exp_sv;
    logic        exp_ov;
    int unsigned exp_ret;
    int unsigned exp_kill;
    int unsigned drop;
  } vec_t;

  function automatic vec_t mk(logic iv, logic [63:0] id, logic [3:0] hold, logic fr,
                              logic [1:0] fi, logic ordy, logic ir, logic [3:0] sv,
                              logic ov, int unsigned ret, int unsigned kil,
                              int unsigned drop);
    vec_t r;
    r.iv = iv; r.id = id; r.hold = hold; r.fr = fr; r.fi = fi; r.ordy = ordy;
    r.exp_ir = ir; r.exp_sv = sv; r.exp_ov = ov;
    r.exp_ret = ret; r.exp_kill = kil; r.drop = drop;
    return r;
  endfunction

  vec_t tbl [$];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; stage_hold = '0;
    flush_req = 1'b0; flush_idx = '0; out_ready = 1'b0;
    #1;
    chk("rst_sv", 64'(stage_valid), 64'd0);
    chk("rst_ov", 64'(out_valid), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_ret", 64'(retired), 64'd0);
    chk("rst_kill", 64'(killed), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    cyc();
    rst = 1'b0;

    // Streaming: first output four edges after the first acceptance.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      in_data = 64'(j);
      cyc();
      chk($sformatf("stream_ov_%0d", j), 64'(out_valid), 64'(j >= 4));
    end
    in_valid = 1'b0;
    drain("stream_drain");
    chk("stream_ret", 64'(retired), 64'd10);

    // Backpressure: fill, stall three cycles, then resume.
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1;
      in_data  = 64'(11 + j);
      #1 chk("bp_fill_ready", 64'(in_ready), 64'd1);
      cyc();
      chk("bp_fill_occ", 64'(occupancy), 64'(j + 1));
    end
    in_data = 64'd15;
    for (int c = 0; c < 3; c++) begin
      #1 chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_occ", 64'(occupancy), 64'd4);
      for (int s = 0; s < 4; s++) begin
        chk($sformatf("bp_data_s%0d", s), stage_data[s*64 +: 64], 64'(14 - s));
      end
      cyc();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 64'(15 + k);
      cyc();
    end
    in_valid = 1'b0;
    drain("bp_drain");
    chk("bp_ret", 64'(retired), 64'd18);
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);

    rst = 1'b1;
    cyc();
    rst = 1'b0;
    sb.delete();

    // iv id hold fr fi ordy | in_ready sv ov retired killed drop
    tbl.push_back(mk(1, 64'hB0, 4'b0000, 0, 0, 1, 1, 4'b0001, 0, 0, 0, 0));
    tbl.push_back(mk(0, 64'h00, 4'b0000, 0, 0, 1, 1, 4'b0010, 0, 0, 0, 0));
    tbl.push_back(mk(1, 64'hA0, 4'b0000, 0, 0, 1, 1, 4'b0101, 0, 0, 0, 0));
    tbl.push_back(mk(0, 64'h00, 4'b0100, 0, 0, 1, 1, 4'b0110, 0, 0, 0, 0));
    tbl.push_back(mk(0, 64'h00, 4'b0100, 0, 0, 1, 1, 4'b0110, 0, 0, 0, 0));
    tbl.push_back(mk(0, 64'h00, 4'b0000, 0, 0, 1, 1, 4'b1100, 1, 0, 0, 0));
    tbl.push_back(mk(0, 64'h00, 4'b0000, 0, 0, 1, 1, 4'b1000, 1, 1, 0, 0));
    tbl.push_back(mk(0, 64'h00, 4'b0000, 0, 0, 1, 1, 4'b0000, 0, 2, 0, 0));
    tbl.push_back(mk(1, 64'hC1, 4'b0000, 0, 0, 0, 1, 4'b0001, 0, 2, 0, 0));
    tbl.push_back(mk(1, 64'hC2, 4'b0000, 0, 0, 0, 1, 4'b0011, 0, 2, 0, 0));
    tbl.push_back(mk(1, 64'hC3, 4'b0000, 0, 0, 0, 1, 4'b0111, 0, 2, 0, 0));
    tbl.push_back(mk(1, 64'hC4, 4'b0000, 0, 0, 0, 1, 4'b1111, 1, 2, 0, 0));
    tbl.push_back(mk(1, 64'hC5, 4'b0000, 1, 1, 1, 0, 4'b1000, 1, 3, 2, 2));
    tbl.push_back(mk(0, 64'h00, 4'b0000, 0, 0, 1, 1, 4'b0000, 0, 4, 2, 0));
    tbl.push_back(mk(1, 64'hD1, 4'b0000, 0, 0, 0, 1, 4'b0001, 0, 4, 2, 0));
    tbl.push_back(mk(1, 64'hD2, 4'b0000, 0, 0, 0, 1, 4'b0011, 0, 4, 2, 0));
    tbl.push_back(mk(1, 64'hD3, 4'b0000, 0, 0, 0, 1, 4'b0111, 0, 4, 2, 0));
    tbl.push_back(mk(1, 64'hD4, 4'b0000, 0, 0, 0, 1, 4'b1111, 1, 4, 2, 0));
    tbl.push_back(mk(0, 64'h00, 4'b0000, 1, 3, 1, 0, 4'b0000, 0, 5, 5, 3));
    tbl.push_back(mk(1, 64'hE1, 4'b0000, 0, 0, 0, 1, 4'b0001, 0, 5, 5, 0));
    tbl.push_back(mk(0, 64'h00, 4'b0001, 1, 0, 0, 0, 4'b0000, 0, 5, 6, 1));

    for (int r = 0; r < tbl.size(); r++) begin
      in_valid   = tbl[r].iv;
      in_data    = tbl[r].id;
      stage_hold = tbl[r].hold;
      flush_req  = tbl[r].fr;
      flush_idx  = tbl[r].fi;
      out_ready  = tbl[r].ordy;
      #1 chk($sformatf("row%0d_in_ready", r), 64'(in_ready), 64'(tbl[r].exp_ir));
      cyc();
      chk($sformatf("row%0d_sv", r), 64'(stage_valid), 64'(tbl[r].exp_sv));
      chk($sformatf("row%0d_ov", r), 64'(out_valid), 64'(tbl[r].exp_ov));
      chk($sformatf("row%0d_occ", r), 64'(occupancy), 64'($countones(tbl[r].exp_sv)));
      chk($sformatf("row%0d_ret", r), 64'(retired), 64'(tbl[r].exp_ret));
      chk($sformatf("row%0d_kill", r), 64'(killed), 64'(tbl[r].exp_kill));
      for (int k = 0; k < int'(tbl[r].drop); k++) begin
        if (sb.size() > 0) void'(sb.pop_back());
      end
    end
    stage_hold = '0;
    flush_req  = 1'b0;
    flush_idx  = '0;
    chk("tbl_sb_empty", 64'(sb.size()), 64'd0);

    // Asynchronous reset between edges with three live slots.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int j = 0; j < 3; j++) begin
      in_data = 64'hF1 + 64'(j);
      cyc();
    end
    in_valid = 1'b0;
    chk("arst_pre_sv", 64'(stage_valid), 64'h7);
    #2 rst = 1'b1;
    #1;
    chk("arst_sv", 64'(stage_valid), 64'd0);
    chk("arst_ov", 64'(out_valid), 64'd0);
    chk("arst_occ", 64'(occupancy), 64'd0);
    chk("arst_ret", 64'(retired), 64'd0);
    chk("arst_kill", 64'(killed), 64'd0);
    sb.delete();
    cyc();
    rst = 1'b0;
    cyc();
    chk("end_sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
